// File: rtl/linalg_pkg.sv
// +----------------------------------------------------------------------+
// | linalg_pkg                                                           |
// | Types, constants and helpers shared by the linear-algebra blocks.    |
// | Contents: fp32_t word type, FP32_W width, idx_w() index-width helper |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package linalg_pkg;

   typedef logic [31:0] fp32_t;

   localparam int FP32_W = 32;

   // Bits needed to index n items; never fewer than one so that
   // single-element ranges still get a legal vector.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mat_colmajor_ctr.sv
// +----------------------------------------------------------------------+
// | mat_colmajor_ctr                                                     |
// | Nested (row, column) read counters walking an MxN matrix in          |
// | column-major order: row is the inner counter, column the outer.      |
// | Ports: clk, rst    - clock, synchronous active-high reset            |
// |        advance     - step to the next element                       |
// |        rd_r, rd_c  - current row / column                           |
// |        last        - current element is (M-1, N-1)                  |
// |        wrap        - advancing past the last element this cycle     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mat_colmajor_ctr
   import linalg_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   output logic [idx_w(M)-1:0]   rd_r,
   output logic [idx_w(N)-1:0]   rd_c,
   output logic                  last,
   output logic                  wrap
);

   localparam int c_rw = idx_w(M);
   localparam int c_cw = idx_w(N);

   logic [c_rw-1:0] rd_r_q, rd_r_d;
   logic [c_cw-1:0] rd_c_q, rd_c_d;
   logic            w_r_end;
   logic            w_c_end;

   assign w_r_end = (rd_r_q == c_rw'(M - 1));
   assign w_c_end = (rd_c_q == c_cw'(N - 1));

   always_comb begin
      rd_r_d = rd_r_q;
      rd_c_d = rd_c_q;
      if (advance) begin
         if (w_r_end) begin
            rd_r_d = '0;
            rd_c_d = w_c_end ? '0 : rd_c_q + 1'b1;
         end else begin
            rd_r_d = rd_r_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_r_q <= '0;
         rd_c_q <= '0;
      end else begin
         rd_r_q <= rd_r_d;
         rd_c_q <= rd_c_d;
      end
   end

   assign rd_r = rd_r_q;
   assign rd_c = rd_c_q;
   assign last = w_r_end && w_c_end;
   assign wrap = advance && last;

endmodule

`default_nettype wire

// File: rtl/mat_transpose_stream.sv
// +----------------------------------------------------------------------+
// | mat_transpose_stream                                                 |
// | Streaming matrix transpose. Accepts an MxN matrix row-major, one     |
// | word per beat, and emits it column-major (the NxM transpose in       |
// | row-major). Two ping-pong banks give 1 word/cycle sustained.         |
// | Ports: clk, rst                     - clock, sync active-high reset  |
// |        in_data/in_valid/in_ready    - input stream                   |
// |        out_data/out_valid/out_ready - output stream                  |
// |        out_last                     - final word of each matrix      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mat_transpose_stream
   import linalg_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 3,
   parameter int W = FP32_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last
);

   localparam int c_depth = M * N;
   localparam int c_aw    = idx_w(c_depth);
   localparam int c_rw    = idx_w(M);
   localparam int c_cw    = idx_w(N);

   // Storage is never reset; the full flags alone decide what is live.
   logic [W-1:0]    mem_q [0:1][0:c_depth-1];

   logic [1:0]      full_q, full_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic [c_aw-1:0] wr_idx_q, wr_idx_d;

   logic [c_rw-1:0] w_rd_r;
   logic [c_cw-1:0] w_rd_c;
   logic            w_ctr_last;
   logic            w_ctr_wrap;
   logic            w_wr_fire;
   logic            w_rd_fire;
   logic            w_wr_last;
   logic [c_aw-1:0] w_rd_addr;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign w_wr_fire = in_valid && in_ready;
   assign w_rd_fire = out_valid && out_ready;
   assign w_wr_last = (wr_idx_q == c_aw'(c_depth - 1));

   mat_colmajor_ctr #(
      .M (M),
      .N (N)
   ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .advance (w_rd_fire),
      .rd_r    (w_rd_r),
      .rd_c    (w_rd_c),
      .last    (w_ctr_last),
      .wrap    (w_ctr_wrap)
   );

   // Element (r, c) of the input sits at row-major address r*N + c.
   assign w_rd_addr = c_aw'(w_rd_r) * c_aw'(N) + c_aw'(w_rd_c);
   assign out_data  = mem_q[rd_bank_q][w_rd_addr];
   assign out_last  = out_valid && w_ctr_last;

   // Fill and drain act on different banks (a write needs !full), so
   // setting one flag and clearing the other in one cycle never collide.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      if (w_wr_fire) begin
         if (w_wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
      if (w_ctr_wrap) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_fire) begin
         mem_q[wr_bank_q][wr_idx_q] <= in_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mat_transpose_stream.sv
// +----------------------------------------------------------------------+
// | tb_mat_transpose_stream                                              |
// | Directed self-checking bench for mat_transpose_stream: a 2x3         |
// | instance plus 1x4 and 1x1 instances for the degenerate shapes.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mat_transpose_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;

   logic [31:0] d14_in_data = '0;
   logic        d14_in_valid = 1'b0;
   logic        d14_in_ready;
   logic [31:0] d14_out_data;
   logic        d14_out_valid;
   logic        d14_out_ready = 1'b0;
   logic        d14_out_last;

   logic [31:0] d11_in_data = '0;
   logic        d11_in_valid = 1'b0;
   logic        d11_in_ready;
   logic [31:0] d11_out_data;
   logic        d11_out_valid;
   logic        d11_out_ready = 1'b0;
   logic        d11_out_last;

   int vecs = 0;
   int errs = 0;

   logic [31:0] src [0:11];
   logic [31:0] exp_q [0:11];

   always #5 clk = ~clk;

   mat_transpose_stream #(.M(2), .N(3), .W(32)) u_dut (
      .clk (clk), .rst (rst),
      .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
      .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
      .out_last (out_last)
   );

   mat_transpose_stream #(.M(1), .N(4), .W(32)) u_dut14 (
      .clk (clk), .rst (rst),
      .in_data (d14_in_data), .in_valid (d14_in_valid), .in_ready (d14_in_ready),
      .out_data (d14_out_data), .out_valid (d14_out_valid), .out_ready (d14_out_ready),
      .out_last (d14_out_last)
   );

   mat_transpose_stream #(.M(1), .N(1), .W(32)) u_dut11 (
      .clk (clk), .rst (rst),
      .in_data (d11_in_data), .in_valid (d11_in_valid), .in_ready (d11_in_ready),
      .out_data (d11_out_data), .out_valid (d11_out_valid), .out_ready (d11_out_ready),
      .out_last (d11_out_last)
   );

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // Column-major reading of each 2x3 matrix in src: k-th output is row k%2, column k/2.
   function automatic void fill_exp();
      for (int mat = 0; mat < 2; mat++)
         for (int k = 0; k < 6; k++)
            exp_q[mat*6 + k] = src[mat*6 + (k % 2)*3 + k/2];
   endfunction

   task automatic feed(input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         in_data  = src[i];
         in_valid = 1'b1;
         guard    = 0;
         while (!in_ready && guard < 100) begin
            clk_step();
            guard++;
         end
         if (guard >= 100) begin
            vecs++; errs++;
            $display("FAIL feed_timeout word %0d: in_ready stuck at %b, required 1", i, in_ready);
         end
         clk_step();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      int guard;
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         guard = 0;
         while (!out_valid && guard < 100) begin
            clk_step();
            guard++;
         end
         vecs++;
         if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k % 6 == 5)) begin
            errs++;
            $display("FAIL %s word %0d: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     tag, k, out_valid, out_data, out_last, exp_q[k], (k % 6 == 5));
         end
         clk_step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_step();
      clk_step();
      rst = 1'b0;
      vecs++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         errs++;
         $display("FAIL reset_2x3: got in_ready=%b out_valid=%b out_last=%b, required 1 0 0",
                  in_ready, out_valid, out_last);
      end
      vecs++;
      if (d14_in_ready !== 1'b1 || d14_out_valid !== 1'b0 || d11_in_ready !== 1'b1 || d11_out_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset_degenerate: got d14 rdy/vld=%b%b d11 rdy/vld=%b%b, required 10 10",
                  d14_in_ready, d14_out_valid, d11_in_ready, d11_out_valid);
      end
   endtask

   task automatic test_basic();
      src[0] = 32'h3F800000; src[1] = 32'h40000000; src[2] = 32'h40400000;
      src[3] = 32'h40800000; src[4] = 32'h40A00000; src[5] = 32'h40C00000;
      exp_q[0] = 32'h3F800000; exp_q[1] = 32'h40800000; exp_q[2] = 32'h40000000;
      exp_q[3] = 32'h40A00000; exp_q[4] = 32'h40400000; exp_q[5] = 32'h40C00000;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data  = src[i];
         in_valid = 1'b1;
         vecs++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_fill word %0d: got in_ready=%b out_valid=%b, required 1 0",
                     i, in_ready, out_valid);
         end
         clk_step();
      end
      in_valid = 1'b0;
      vecs++;
      if (out_valid !== 1'b1) begin
         errs++;
         $display("FAIL basic_latency: got out_valid=%b one cycle after 6th input, required 1", out_valid);
      end
      drain(6, "basic_order");
      vecs++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL basic_empty: got out_valid=%b after drain, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lasts;
      lasts = 0;
      for (int i = 0; i < 12; i++) src[i] = 32'h1000 + 32'(i);
      fill_exp();
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               in_data  = src[i];
               in_valid = 1'b1;
               vecs++;
               if (in_ready !== 1'b1) begin
                  errs++;
                  $display("FAIL b2b_in_ready word %0d: got %b, required 1", i, in_ready);
               end
               clk_step();
            end
            in_valid = 1'b0;
         end
         begin
            int guard;
            guard = 0;
            out_ready = 1'b1;
            while (!out_valid && guard < 50) begin
               clk_step();
               guard++;
            end
            for (int k = 0; k < 12; k++) begin
               vecs++;
               if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k % 6 == 5)) begin
                  errs++;
                  $display("FAIL b2b_out word %0d: got valid=%b data=%h last=%b, required 1 %h %b",
                           k, out_valid, out_data, out_last, exp_q[k], (k % 6 == 5));
               end
               if (out_last === 1'b1) lasts++;
               clk_step();
            end
            out_ready = 1'b0;
         end
      join
      vecs++;
      if (lasts != 2) begin
         errs++;
         $display("FAIL b2b_last_count: got %0d out_last pulses, required 2", lasts);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 12; i++) src[i] = 32'hA0000000 + 32'(i * 3);
      fill_exp();
      out_ready = 1'b0;
      feed(12);
      vecs++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errs++;
         $display("FAIL bp_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         vecs++;
         if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== (k % 6 == 5)) begin
            errs++;
            $display("FAIL bp_out word %0d: got valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_q[k], (k % 6 == 5));
         end
         if (k <= 5) begin
            vecs++;
            if (in_ready !== 1'b0) begin
               errs++;
               $display("FAIL bp_in_ready_low word %0d: got %b, required 0", k, in_ready);
            end
         end
         clk_step();
         if (k == 5) begin
            vecs++;
            if (in_ready !== 1'b1) begin
               errs++;
               $display("FAIL bp_in_ready_rise: got %b after first out_last, required 1", in_ready);
            end
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random_stall();
      fork
         begin
            int sent, cyc;
            sent = 0;
            cyc  = 0;
            while (sent < 300 && cyc < 6000) begin
               if ($urandom_range(0, 1) == 1) begin
                  in_valid = 1'b1;
                  in_data  = 32'(sent);
               end else begin
                  in_valid = 1'b0;
               end
               if (in_valid && in_ready) sent++;
               clk_step();
               cyc++;
            end
            in_valid = 1'b0;
            vecs++;
            if (sent != 300) begin
               errs++;
               $display("FAIL rand_send_timeout: got %0d words accepted, required 300", sent);
            end
         end
         begin
            int got, cyc, j;
            logic [31:0] e;
            got = 0;
            cyc = 0;
            while (got < 300 && cyc < 6000) begin
               out_ready = ($urandom_range(0, 1) == 1);
               if (out_valid && out_ready) begin
                  j = got % 6;
                  e = 32'((got / 6) * 6 + (j % 2) * 3 + j / 2);
                  vecs++;
                  if (out_data !== e || out_last !== (j == 5)) begin
                     errs++;
                     $display("FAIL rand_word %0d: got data=%h last=%b, required %h %b",
                              got, out_data, out_last, e, (j == 5));
                  end
                  got++;
               end
               clk_step();
               cyc++;
            end
            out_ready = 1'b0;
            vecs++;
            if (got != 300) begin
               errs++;
               $display("FAIL rand_recv_timeout: got %0d words delivered, required 300", got);
            end
         end
      join
      clk_step();
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rand_idle: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 6; i++) src[i] = 32'hDEAD0000 + 32'(i);
      feed(4);
      rst = 1'b1;
      clk_step();
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rst_partial: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      rst = 1'b0;
      feed(6);
      out_ready = 1'b1;
      clk_step();
      clk_step();
      rst = 1'b1;
      out_ready = 1'b0;
      clk_step();
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rst_draining: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) src[i] = 32'h5A000010 + 32'(i * 16);
      fill_exp();
      feed(6);
      drain(6, "rst_fresh");
      vecs++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL rst_stale: got out_valid=%b after fresh matrix, required 0", out_valid);
      end
   endtask

   task automatic test_degenerate_1x4();
      logic [31:0] w [0:3];
      w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
      for (int i = 0; i < 4; i++) begin
         d14_in_data  = w[i];
         d14_in_valid = 1'b1;
         vecs++;
         if (d14_in_ready !== 1'b1) begin
            errs++;
            $display("FAIL d14_in_ready word %0d: got %b, required 1", i, d14_in_ready);
         end
         clk_step();
      end
      d14_in_valid  = 1'b0;
      d14_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vecs++;
         if (d14_out_valid !== 1'b1 || d14_out_data !== w[k] || d14_out_last !== (k == 3)) begin
            errs++;
            $display("FAIL d14_out word %0d: got valid=%b data=%h last=%b, required 1 %h %b",
                     k, d14_out_valid, d14_out_data, d14_out_last, w[k], (k == 3));
         end
         clk_step();
      end
      d14_out_ready = 1'b0;
   endtask

   task automatic test_degenerate_1x1();
      logic [31:0] w;
      for (int i = 0; i < 3; i++) begin
         w = 32'hC0DE0000 + 32'(i * 5);
         d11_in_data  = w;
         d11_in_valid = 1'b1;
         vecs++;
         if (d11_in_ready !== 1'b1 || d11_out_valid !== 1'b0) begin
            errs++;
            $display("FAIL d11_pre word %0d: got in_ready=%b out_valid=%b, required 1 0",
                     i, d11_in_ready, d11_out_valid);
         end
         clk_step();
         d11_in_valid = 1'b0;
         vecs++;
         if (d11_out_valid !== 1'b1 || d11_out_data !== w || d11_out_last !== 1'b1) begin
            errs++;
            $display("FAIL d11_out word %0d: got valid=%b data=%h last=%b, required 1 %h 1",
                     i, d11_out_valid, d11_out_data, d11_out_last, w);
         end
         d11_out_ready = 1'b1;
         clk_step();
         d11_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_random_stall();
      test_reset_midop();
      test_degenerate_1x4();
      test_degenerate_1x1();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire
